// File: rtl/flash_mem_responder.sv
// Read-only Avalon-MM flash stand-in: address-derived data, wait-request stalling, fixed read latency.
// Build option FLASH_RESP_LFSR_STALL_EN draws a 0..3 cycle stall per request from an 8-bit LFSR.
module flash_mem_responder #(
    parameter int          WAIT_CYCLES  = 2,
    parameter int          READ_LATENCY = 3,
    parameter int          MAX_PENDING  = 2,
    parameter logic [15:0] DATA_SEED    = 16'h0000
) (
    input  logic        CLK50MHZ,
    input  logic        reset_n,
    input  logic        flash_mem_read,
    input  logic [22:0] flash_mem_address,
    input  logic [3:0]  flash_mem_byteenable,
    output logic        flash_mem_waitrequest,
    output logic        flash_mem_readdatavalid,
    output logic [31:0] flash_mem_readdata,
    output logic [15:0] read_count
);

    typedef enum logic [1:0] {IDLE, STALL, GRANT} state_t;

    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    state_t      state, state_next;
    logic [3:0]  stall_cnt, stall_cnt_next;
    logic [3:0]  stall_len;
    logic [3:0]  pending;
    logic        room;
    logic        accept;
    logic        vld_in [READ_LATENCY];
    logic [31:0] data_in [READ_LATENCY];
    logic        vld_p [READ_LATENCY];
    logic [31:0] data_p [READ_LATENCY];
    logic        unused_addr_hi;

    assign unused_addr_hi = ^flash_mem_address[22:16];

    function automatic logic [31:0] make_word(input logic [15:0] addr, input logic [3:0] be);
        logic [31:0] w;
        w = {addr ^ DATA_SEED, ~addr};
        for (int i = 0; i < 4; i++) begin
            if (!be[i]) w[8*i +: 8] = 8'h00;
        end
        return w;
    endfunction

`ifdef FLASH_RESP_LFSR_STALL_EN
    logic [7:0] lfsr;

    // x^8 + x^6 + x^5 + x^4 + 1, free-running from the seed
    always_ff @(posedge CLK50MHZ or negedge reset_n) begin
        if (!reset_n) lfsr <= 8'h5A;
        else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign stall_len = {2'b00, lfsr[1:0]};
`else
    assign stall_len = 4'(WAIT_CYCLES);
`endif

    assign room = (pending < MAX_P);

    // The IDLE cycle of a request is the first stall cycle; stall_cnt counts the remaining STALL cycles.
    always_comb begin
        state_next            = state;
        stall_cnt_next        = stall_cnt;
        flash_mem_waitrequest = 1'b1;
        accept                = 1'b0;
        case (state)
            IDLE: begin
                if (flash_mem_read) begin
                    if (stall_len == 4'd0) begin
                        flash_mem_waitrequest = ~room;
                        accept                = room;
                    end else if (stall_len == 4'd1) begin
                        state_next = GRANT;
                    end else begin
                        state_next     = STALL;
                        stall_cnt_next = stall_len - 4'd2;
                    end
                end
            end
            STALL: begin
                if (!flash_mem_read)        state_next = IDLE;
                else if (stall_cnt == 4'd0) state_next = GRANT;
                else                        stall_cnt_next = stall_cnt - 4'd1;
            end
            GRANT: begin
                flash_mem_waitrequest = ~room;
                if (!flash_mem_read) begin
                    state_next = IDLE;
                end else if (room) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset_n) begin
            flash_mem_waitrequest = 1'b1;
            accept                = 1'b0;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            stall_cnt  <= 4'd0;
            pending    <= 4'd0;
            read_count <= 16'd0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            case ({accept, flash_mem_readdatavalid})
                2'b10:   pending <= pending + 4'd1;
                2'b01:   pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
            if (accept) read_count <= read_count + 16'd1;
        end
    end

    // Return pipeline: stage 0 captures the accept, the last stage drives the outputs
    for (genvar g = 0; g < READ_LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign vld_in[g]  = accept;
            assign data_in[g] = make_word(flash_mem_address[15:0], flash_mem_byteenable);
        end else begin : g_tail
            assign vld_in[g]  = vld_p[g-1];
            assign data_in[g] = data_p[g-1];
        end
    end

    always_ff @(posedge CLK50MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_in[i];
                if (vld_in[i]) data_p[i] <= data_in[i];
            end
        end
    end

    assign flash_mem_readdatavalid = vld_p[READ_LATENCY-1];
    assign flash_mem_readdata      = data_p[READ_LATENCY-1];

endmodule

// File: tb/tb_flash_mem_responder.sv
// Bench for flash_mem_responder: three instances (default, zero-wait, long-latency counter-wrap)
// checked by a transaction-level reference model plus table-driven and hand-written sequences.
module tb_flash_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        rd [3];
    logic [22:0] ad [3];
    logic [3:0]  be [3];
    logic        wr [3];
    logic        rdv [3];
    logic [31:0] rdata [3];
    logic [15:0] rcnt [3];

    int total = 0;
    int bad   = 0;
    bit wrap_done = 0;

    flash_mem_responder #(.WAIT_CYCLES(2), .READ_LATENCY(3), .MAX_PENDING(2), .DATA_SEED(16'h0000)) dut0 (
        .CLK50MHZ(clk), .reset_n(rst_n), .flash_mem_read(rd[0]), .flash_mem_address(ad[0]),
        .flash_mem_byteenable(be[0]), .flash_mem_waitrequest(wr[0]), .flash_mem_readdatavalid(rdv[0]),
        .flash_mem_readdata(rdata[0]), .read_count(rcnt[0]));

    flash_mem_responder #(.WAIT_CYCLES(0), .READ_LATENCY(3), .MAX_PENDING(2), .DATA_SEED(16'h0000)) dut1 (
        .CLK50MHZ(clk), .reset_n(rst_n), .flash_mem_read(rd[1]), .flash_mem_address(ad[1]),
        .flash_mem_byteenable(be[1]), .flash_mem_waitrequest(wr[1]), .flash_mem_readdatavalid(rdv[1]),
        .flash_mem_readdata(rdata[1]), .read_count(rcnt[1]));

    flash_mem_responder #(.WAIT_CYCLES(0), .READ_LATENCY(8), .MAX_PENDING(8), .DATA_SEED(16'hA5C3)) dut2 (
        .CLK50MHZ(clk), .reset_n(rst2_n), .flash_mem_read(rd[2]), .flash_mem_address(ad[2]),
        .flash_mem_byteenable(be[2]), .flash_mem_waitrequest(wr[2]), .flash_mem_readdatavalid(rdv[2]),
        .flash_mem_readdata(rdata[2]), .read_count(rcnt[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          wp [3] = '{2, 0, 0};
    int          lp [3] = '{3, 3, 8};
    int          mp [3] = '{2, 2, 8};
    logic [15:0] sp [3] = '{16'h0000, 16'h0000, 16'hA5C3};

    bit          slot_v [3][16];
    logic [31:0] slot_d [3][16];
    int          outst [3];
    int          reqw [3];
    int          cyc [3];
    logic [15:0] mcnt [3];
    logic [31:0] lastd [3];

    function automatic logic [31:0] ref_word(input logic [22:0] a, input logic [3:0] b, input logic [15:0] seed);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return {a[15:0] ^ seed, 16'hFFFF - a[15:0]} & mask;
    endfunction

    task automatic model_step(input int u);
        logic  rs;
        bit    room, expwr, acc;
        int    n;
        string tag;
        tag = $sformatf("u%0d", u);
        rs  = (u == 2) ? rst2_n : rst_n;
        if (!rs) begin
            check({tag, "_reset_wr"}, 32'(wr[u]), 32'd1);
            check({tag, "_reset_rdv"}, 32'(rdv[u]), 32'd0);
            check({tag, "_reset_rdata"}, rdata[u], 32'h0);
            check({tag, "_reset_count"}, 32'(rcnt[u]), 32'd0);
            for (int s = 0; s < 16; s++) slot_v[u][s] = 1'b0;
            outst[u] = 0; reqw[u] = 0; cyc[u] = 0; mcnt[u] = 16'd0; lastd[u] = 32'h0;
            return;
        end
        n     = cyc[u] % 16;
        room  = (outst[u] < mp[u]);
        expwr = 1'b1;
        if (rd[u]) begin
            expwr = (reqw[u] < wp[u]) ? 1'b1 : !room;
            check({tag, "_waitrequest"}, 32'(wr[u]), 32'(expwr));
        end
        check({tag, "_readdatavalid"}, 32'(rdv[u]), 32'(slot_v[u][n]));
        if (slot_v[u][n]) lastd[u] = slot_d[u][n];
        check({tag, "_readdata"}, rdata[u], lastd[u]);
        check({tag, "_read_count"}, 32'(rcnt[u]), 32'(mcnt[u]));
        acc = rd[u] && !expwr;
        if (slot_v[u][n]) begin
            slot_v[u][n] = 1'b0;
            outst[u]--;
        end
        if (acc) begin
            slot_v[u][(cyc[u] + lp[u]) % 16] = 1'b1;
            slot_d[u][(cyc[u] + lp[u]) % 16] = ref_word(ad[u], be[u], sp[u]);
            outst[u]++;
            mcnt[u]++;
            reqw[u] = 0;
        end else if (!rd[u]) begin
            reqw[u] = 0;
        end else if (reqw[u] < 64) begin
            reqw[u]++;
        end
        cyc[u]++;
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) model_step(u);
    end

    // ---------------- directed helpers ----------------
    task automatic do_read0(input logic [22:0] a, input logic [3:0] b, input logic [31:0] exp);
        int waits, lat;
        bit ok;
        @(posedge clk); #1;
        rd[0] = 1'b1; ad[0] = a; be[0] = b;
        waits = 0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!wr[0]) begin ok = 1'b1; break; end
            waits++;
        end
        check("accept_seen", 32'(ok), 32'd1);
        if (!ok) begin
            rd[0] = 1'b0;
            return;
        end
        check("wait_cycles", 32'(waits), 32'd2);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        lat = 0; ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rdv[0]) begin ok = 1'b1; break; end
        end
        check("valid_seen", 32'(ok), 32'd1);
        check("latency", 32'(lat), 32'd3);
        check("rdata", rdata[0], exp);
    endtask

    // ---------------- counter wrap on dut2 ----------------
    initial begin
        ad[2] = 23'h0; be[2] = 4'hF;
        forever begin
            @(posedge clk); #1;
            if (rd[2]) begin
                ad[2] = 23'($urandom);
                be[2] = 4'($urandom);
            end
        end
    end

    initial begin
        bit seen;
        rst2_n = 1'b0; rd[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst2_n = 1'b1; rd[2] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 80000; c++) begin
            @(negedge clk);
            if (rcnt[2] == 16'hFFFF) begin seen = 1'b1; break; end
        end
        check("wrap_reach_ffff", 32'(seen), 32'd1);
        if (seen) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rcnt[2] != 16'hFFFF) break;
            end
            check("wrap_to_zero", 32'(rcnt[2]), 32'd0);
        end
        @(posedge clk); #1 rd[2] = 1'b0;
        wrap_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    typedef struct {
        logic [22:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   acc_c [3];
        int   val_c [3];
        logic [31:0] val_d [3];
        int   nacc, nval, nv;
        bit   done;

        tbl[0] = '{23'h000010, 4'hF,    32'h0010FFEF};
        tbl[1] = '{23'h0000FF, 4'b0011, 32'h0000FF00};
        tbl[2] = '{23'h7FFFFF, 4'hF,    32'hFFFF0000};
        tbl[3] = '{23'h123456, 4'b1010, 32'h3400CB00};
        tbl[4] = '{23'h00ABCD, 4'b0100, 32'h00CD0000};
        tbl[5] = '{23'h000000, 4'hF,    32'h0000FFFF};

        rst_n = 1'b0;
        rd[0] = 1'b0; ad[0] = 23'h0; be[0] = 4'h0;
        rd[1] = 1'b0; ad[1] = 23'h0; be[1] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", 32'(wr[0]), 32'd1);
        check("rst_rdv", 32'(rdv[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_count", 32'(rcnt[0]), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_read0(tbl[i].addr, tbl[i].be, tbl[i].data);
            check("count_after_read", 32'(rcnt[0]), 32'(i + 1));
        end

        // read withdrawn during STALL
        @(posedge clk); #1;
        rd[0] = 1'b1; ad[0] = 23'h000055; be[0] = 4'hF;
        @(negedge clk);
        check("drop_wr_idle", 32'(wr[0]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_wr_stall", 32'(wr[0]), 32'd1);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdv[0]) nv++;
        end
        check("drop_no_valid", 32'(nv), 32'd0);
        check("drop_count", 32'(rcnt[0]), 32'd6);
        do_read0(23'h000ABC, 4'hF, 32'h0ABCF543);
        check("count_after_drop", 32'(rcnt[0]), 32'd7);

        // zero-wait back-to-back with MAX_PENDING=2
        @(posedge clk); #1;
        rd[1] = 1'b1; ad[1] = 23'd1; be[1] = 4'hF;
        nacc = 0; nval = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rdv[1] && nval < 3) begin
                val_c[nval] = c; val_d[nval] = rdata[1]; nval++;
            end
            if (rd[1] && !wr[1] && nacc < 3) begin
                acc_c[nacc] = c; nacc++;
            end
            @(posedge clk); #1;
            if (nacc >= 3) rd[1] = 1'b0;
            else           ad[1] = 23'(nacc + 1);
        end
        rd[1] = 1'b0;
        check("b2b_accepts", 32'(nacc), 32'd3);
        check("b2b_valids", 32'(nval), 32'd3);
        if (nacc == 3 && nval == 3) begin
            check("b2b_acc0", 32'(acc_c[0]), 32'd0);
            check("b2b_acc1", 32'(acc_c[1]), 32'd1);
            check("b2b_acc2", 32'(acc_c[2]), 32'd4);
            check("b2b_val0_cyc", 32'(val_c[0]), 32'd3);
            check("b2b_val1_cyc", 32'(val_c[1]), 32'd4);
            check("b2b_val2_cyc", 32'(val_c[2]), 32'd7);
            check("b2b_data0", val_d[0], 32'h0001FFFE);
            check("b2b_data1", val_d[1], 32'h0002FFFD);
            check("b2b_data2", val_d[2], 32'h0003FFFC);
        end
        check("b2b_count", 32'(rcnt[1]), 32'd3);

        // reset one cycle after an accept
        @(posedge clk); #1;
        rd[0] = 1'b1; ad[0] = 23'h000020; be[0] = 4'hF;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!wr[0]) begin done = 1'b1; break; end
        end
        check("rstmid_accept_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_wr", 32'(wr[0]), 32'd1);
        check("rstmid_rdv", 32'(rdv[0]), 32'd0);
        check("rstmid_rdata", rdata[0], 32'h0);
        check("rstmid_count", 32'(rcnt[0]), 32'd0);
        check("rstmid_count1", 32'(rcnt[1]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdv[0]) nv++;
        end
        check("rstmid_no_valid", 32'(nv), 32'd0);

        // randomized traffic, including withdrawn requests
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                rd[u] = ($urandom_range(0, 9) != 0);
                ad[u] = 23'($urandom);
                be[u] = 4'($urandom);
            end
        end
        @(posedge clk); #1;
        rd[0] = 1'b0; rd[1] = 1'b0;
        repeat (12) @(posedge clk);

        done = 1'b0;
        for (int c = 0; c < 100000; c++) begin
            if (wrap_done) begin done = 1'b1; break; end
            @(posedge clk);
        end
        check("wrap_finished", 32'(done), 32'd1);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
